// File: rtl/conv_window_gen_pkg.sv
// -----------------------------------------------------------------------------
// conv_window_gen_pkg
// Shared definitions for the 3x3 convolution window generator: pixel and
// dimension widths, window packing width, FSM state encoding and the tap-index
// helper used to place each pixel in the packed MAC input word.
// -----------------------------------------------------------------------------
package conv_window_gen_pkg;

  localparam int DATA_WIDTH    = 8;
  localparam int KERNEL_SIZE   = 3;
  localparam int MAC_IN_NUM    = KERNEL_SIZE * KERNEL_SIZE;
  localparam int MAX_IMG_WIDTH = 224;
  localparam int DIM_WIDTH     = 8;
  localparam int WIN_WIDTH     = MAC_IN_NUM * DATA_WIDTH;

  // Window coordinates: row 0 is the oldest line, column 2 the newest pixel.
  localparam int ROW_OLDEST = 0;
  localparam int ROW_MID    = 1;
  localparam int ROW_NEWEST = KERNEL_SIZE - 1;
  localparam int COL_NEWEST = KERNEL_SIZE - 1;

  localparam logic [DIM_WIDTH-1:0] DIM_ZERO  = {DIM_WIDTH{1'b0}};
  localparam logic [DIM_WIDTH-1:0] DIM_ONE   = DIM_WIDTH'(1);
  localparam logic [DIM_WIDTH-1:0] DIM_TWO   = DIM_WIDTH'(2);
  localparam logic [DIM_WIDTH-1:0] MIN_DIM   = DIM_WIDTH'(KERNEL_SIZE);
  localparam logic [DIM_WIDTH-1:0] MAX_W_DIM = DIM_WIDTH'(MAX_IMG_WIDTH);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Tap k = r*KERNEL_SIZE + c occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
  function automatic int unsigned tap_idx(input int unsigned r, input int unsigned c);
    return r * KERNEL_SIZE + c;
  endfunction

endpackage

// File: rtl/conv_window_gen_if.sv
// -----------------------------------------------------------------------------
// conv_window_gen_if
// Bundles the frame control, pixel stream and window output signals of the
// window generator.
//   master : the pixel source / frame controller (drives *_in, observes *_out)
//   slave  : the window generator itself
// -----------------------------------------------------------------------------
interface conv_window_gen_if;
  import conv_window_gen_pkg::*;

  logic                  frame_start_in;
  logic [DIM_WIDTH-1:0]  img_width_in;
  logic [DIM_WIDTH-1:0]  img_height_in;
  logic [DATA_WIDTH-1:0] pix_in;
  logic                  pix_valid_in;
  logic [WIN_WIDTH-1:0]  win_data_out;
  logic                  win_valid_out;
  logic                  frame_done_out;
  logic                  busy_out;
  logic                  cfg_err_out;

  modport master (
    output frame_start_in, img_width_in, img_height_in, pix_in, pix_valid_in,
    input  win_data_out, win_valid_out, frame_done_out, busy_out, cfg_err_out
  );

  modport slave (
    input  frame_start_in, img_width_in, img_height_in, pix_in, pix_valid_in,
    output win_data_out, win_valid_out, frame_done_out, busy_out, cfg_err_out
  );

endinterface

// File: rtl/conv_window_gen_line_buf.sv
// -----------------------------------------------------------------------------
// conv_line_buf
// One image line of pixel storage. Read is combinational so the window can
// take the stored pixel in the same cycle the new pixel arrives; the write
// lands at the same address on the clock edge (read-before-write).
// Contents are not reset: a location is always rewritten before its value
// can reach a valid window.
// Ports:
//   clk      clock
//   we_i     write enable
//   addr_i   column address (read and write)
//   wdata_i  pixel to store
//   rdata_o  pixel currently stored at addr_i
// -----------------------------------------------------------------------------
module conv_line_buf #(
  parameter int DEPTH = 224,
  parameter int DW    = 8,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];

  assign rdata_o = mem_q[addr_i];

  // Synchronous write port
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

endmodule

// File: rtl/conv_window_gen.sv
// -----------------------------------------------------------------------------
// conv_window_gen
// Converts a raster-order pixel stream into packed 3x3 sliding windows for the
// MAC array. Two line buffers hold the previous lines; a 3x3 register window
// shifts one column per accepted pixel. A window is emitted one cycle after a
// pixel at row>=2, col>=2 is accepted.
// Ports:
//   clk   clock
//   rstn  asynchronous active-low reset
//   bus   conv_window_gen_if.slave: frame_start_in, img_width_in,
//         img_height_in, pix_in, pix_valid_in, win_data_out, win_valid_out,
//         frame_done_out, busy_out, cfg_err_out
// Build option:
//   CONV_STRIDE2_EN  emit only windows whose top-left corner has even row and
//                    column (stride 2); frame_done_out is unaffected.
// -----------------------------------------------------------------------------
module conv_window_gen
  import conv_window_gen_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  conv_window_gen_if.slave  bus
);

  state_e                state_q;
  logic [DIM_WIDTH-1:0]  width_q, height_q, col_q, row_q;
  logic                  busy_q, cfg_err_q, win_valid_q, frame_done_q;
  logic [WIN_WIDTH-1:0]  win_q, win_d, win_out_q;

  logic [DATA_WIDTH-1:0] lb0_rd_s, lb1_rd_s;
  logic                  legal_cfg_s, accept_s, last_col_s, last_pix_s;
  logic                  emit_s, stride_ok_s;
  logic [DIM_WIDTH-1:0]  cur_w_s, cur_h_s, acc_col_s, acc_row_s, col_nx_s, row_nx_s;

  assign legal_cfg_s = (bus.img_width_in >= MIN_DIM) && (bus.img_width_in <= MAX_W_DIM)
                    && (bus.img_height_in >= MIN_DIM);

  // A pixel arriving with frame_start_in belongs to the new frame at (0,0),
  // so the position and geometry used for it come from the new config.
  assign accept_s  = bus.pix_valid_in && (bus.frame_start_in ? legal_cfg_s : (state_q == ST_RUN));
  assign cur_w_s   = bus.frame_start_in ? bus.img_width_in  : width_q;
  assign cur_h_s   = bus.frame_start_in ? bus.img_height_in : height_q;
  assign acc_col_s = bus.frame_start_in ? DIM_ZERO : col_q;
  assign acc_row_s = bus.frame_start_in ? DIM_ZERO : row_q;

  assign last_col_s = (acc_col_s == (cur_w_s - DIM_ONE));
  assign last_pix_s = last_col_s && (acc_row_s == (cur_h_s - DIM_ONE));
  assign col_nx_s   = last_col_s ? DIM_ZERO : (acc_col_s + DIM_ONE);
  assign row_nx_s   = last_col_s ? (acc_row_s + DIM_ONE) : acc_row_s;

`ifdef CONV_STRIDE2_EN
  // (row-2) and (col-2) even is the same as row and col even.
  assign stride_ok_s = ~acc_row_s[0] & ~acc_col_s[0];
`else
  assign stride_ok_s = 1'b1;
`endif

  assign emit_s = accept_s && stride_ok_s && (acc_row_s >= DIM_TWO) && (acc_col_s >= DIM_TWO);

  conv_line_buf #(
    .DEPTH (MAX_IMG_WIDTH),
    .DW    (DATA_WIDTH),
    .AW    (DIM_WIDTH)
  ) u_lb0 (
    .clk     (clk),
    .we_i    (accept_s),
    .addr_i  (acc_col_s),
    .wdata_i (bus.pix_in),
    .rdata_o (lb0_rd_s)
  );

  // lb1 receives the line that lb0 is about to overwrite.
  conv_line_buf #(
    .DEPTH (MAX_IMG_WIDTH),
    .DW    (DATA_WIDTH),
    .AW    (DIM_WIDTH)
  ) u_lb1 (
    .clk     (clk),
    .we_i    (accept_s),
    .addr_i  (acc_col_s),
    .wdata_i (lb0_rd_s),
    .rdata_o (lb1_rd_s)
  );

  // Next window: shift columns toward the oldest, insert the new right column
  always_comb begin
    win_d = win_q;
    for (int r = 0; r < KERNEL_SIZE; r++) begin
      for (int c = 0; c < KERNEL_SIZE - 1; c++) begin
        win_d[tap_idx(r, c) * DATA_WIDTH +: DATA_WIDTH] =
          win_q[tap_idx(r, c + 1) * DATA_WIDTH +: DATA_WIDTH];
      end
    end
    win_d[tap_idx(ROW_OLDEST, COL_NEWEST) * DATA_WIDTH +: DATA_WIDTH] = lb1_rd_s;
    win_d[tap_idx(ROW_MID,    COL_NEWEST) * DATA_WIDTH +: DATA_WIDTH] = lb0_rd_s;
    win_d[tap_idx(ROW_NEWEST, COL_NEWEST) * DATA_WIDTH +: DATA_WIDTH] = bus.pix_in;
  end

  // FSM, counters, config latches and registered status/qualifier outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      busy_q       <= 1'b0;
      cfg_err_q    <= 1'b0;
      width_q      <= DIM_ZERO;
      height_q     <= DIM_ZERO;
      col_q        <= DIM_ZERO;
      row_q        <= DIM_ZERO;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      // A restart can never emit (position 0,0), which drops the old frame.
      win_valid_q  <= emit_s;
      frame_done_q <= accept_s && last_pix_s;

      if (bus.frame_start_in) begin
        width_q   <= bus.img_width_in;
        height_q  <= bus.img_height_in;
        cfg_err_q <= ~legal_cfg_s;
        if (legal_cfg_s) begin
          state_q <= ST_RUN;
          busy_q  <= 1'b1;
        end else begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      end else if (accept_s && last_pix_s) begin
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
      end else begin
        state_q <= state_q;
        busy_q  <= busy_q;
      end

      if (accept_s) begin
        col_q <= col_nx_s;
        row_q <= row_nx_s;
      end else if (bus.frame_start_in) begin
        col_q <= DIM_ZERO;
        row_q <= DIM_ZERO;
      end else begin
        col_q <= col_q;
        row_q <= row_q;
      end
    end
  end

  // Window shift register and held output word
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      win_q     <= {WIN_WIDTH{1'b0}};
      win_out_q <= {WIN_WIDTH{1'b0}};
    end else begin
      if (accept_s) begin
        win_q <= win_d;
      end
      if (emit_s) begin
        win_out_q <= win_d;
      end
    end
  end

  assign bus.win_data_out   = win_out_q;
  assign bus.win_valid_out  = win_valid_q;
  assign bus.frame_done_out = frame_done_q;
  assign bus.busy_out       = busy_q;
  assign bus.cfg_err_out    = cfg_err_q;

endmodule
